spad_fill_ctrl: RTL and testbench
=================================

Name: spad_fill_ctrl

Overview:
- Write-side sequencer for the scratchpad memory group. Accepts 128-bit feature words from the feature-load stream via a valid/ready handshake.
- Steers each word into one of KERNEL_SIZE FIFO lines: LINE_WORDS words per line, lines filled in order 0..KERNEL_SIZE-1.
- Drives the scratchpad's line-select, data and write-enable. Applies backpressure from the scratchpad's group_full flag.
- Pulses done when one full kernel window has been written.

Parameters:
- KERNEL_SIZE, 5, number of FIFO lines in the scratchpad group (max 16, since the line select is 4 bits).
- DATA_BUS_WIDTH, 128, width of the feature word.
- LEN_WIDTH, 8, width of the per-line word count.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a fill. Honoured only in IDLE.
- abort  in  1  synchronous abort. Returns to IDLE with no done pulse.
- line_words  in  LEN_WIDTH  words per line. Sampled on an accepted start.
- in_data  in  DATA_BUS_WIDTH  feature word from the load stream.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  controller accepts in_data this cycle.
- group_full  in  1  scratchpad full flag, used as backpressure.
- wr_mem_line  out  4  target FIFO line index.
- o_data  out  DATA_BUS_WIDTH  word to the scratchpad.
- wr_en  out  1  write strobe to the selected line.
- busy  out  1  high while not in IDLE.
- done  out  1  one-cycle pulse after the last write of a window.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE; all counters 0.
  - in_ready=0, wr_en=0, wr_mem_line=0, o_data=0, busy=0, done=0.
- States:
  - IDLE: start=1 latches line_words into len_q. Clears word_cnt and line_cnt. Goes to FILL. If line_words==0, goes directly to DONE instead.
  - FILL: in_ready = !group_full (combinational). A transfer occurs when in_valid && in_ready.
    - On each transfer, on the next edge: o_data=in_data, wr_mem_line=line_cnt, wr_en=1. This is a one-cycle registered latency. wr_en is 0 in every cycle without a transfer.
    - word_cnt increments per transfer. When word_cnt==len_q-1 on a transfer: word_cnt goes to 0 and line_cnt increments.
    - When line_cnt==KERNEL_SIZE-1 and word_cnt==len_q-1 on a transfer, go to DONE.
  - DONE: done=1 for exactly one cycle, in the cycle following the last wr_en. in_ready=0. Then return to IDLE.
- in_ready is 0 in IDLE and DONE. No word is consumed outside FILL.
- Backpressure: group_full=1 deasserts in_ready in the same cycle. No transfer occurs even if in_valid=1. in_data must be held by the source per the valid/ready rule.
- start while busy is ignored. line_words changes after start are ignored.
- abort=1 in any state, on the next edge:
  - state=IDLE, counters cleared, wr_en=0, done=0.
  - A transfer accepted in the same cycle as abort is discarded: no wr_en is issued for it.
  - abort has priority over start.
- Simultaneous start and done: a start in the DONE cycle is ignored. A new start is honoured from IDLE one cycle later.
- Total writes per window = KERNEL_SIZE*len_q. wr_mem_line never exceeds KERNEL_SIZE-1.
- Upper bits of wr_mem_line are zero when KERNEL_SIZE<16.
- Counters have no wrap-around hazard: word_cnt is LEN_WIDTH bits, line_cnt is 4 bits.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then in_valid=1 with no start -> in_ready=0, wr_en never 1, busy=0, done=0.
- Basic fill: line_words=3, start, in_valid held 1, data 0,1,2,...,14 -> 15 wr_en pulses, each one cycle after its transfer. wr_mem_line sequence 0,0,0,1,1,1,...,4,4,4. o_data matches input order. done pulses exactly once, the cycle after the 15th write.
- Backpressure: line_words=2. Assert group_full for 4 cycles after the 3rd transfer -> in_ready=0 and no wr_en during those cycles. The 4th word is written to line 1 after release. Total writes = 10.
- Gapped source: in_valid toggles 1/0 each cycle, line_words=4 -> 20 writes. Line changes exactly after every 4th write. done follows the 20th write.
- Zero length: line_words=0 with start -> no wr_en. done pulses 2 cycles after start; busy high for 1 cycle.
- Abort mid-window: line_words=4. Assert abort during the 7th transfer -> the 7th word is not written (6 writes total), no done. A following start refills from line 0 with word_cnt=0.

Source files
------------

// File: rtl/spad_fill_ctrl_if.sv
// rtl/spad_fill_ctrl_if.sv - feature-load stream and scratchpad write port bundle
interface spad_fill_ctrl_if #(
    parameter int DATA_BUS_WIDTH = 128
);
    logic [DATA_BUS_WIDTH-1:0] in_data;
    logic                      in_valid;
    logic                      in_ready;
    logic                      group_full;
    logic [3:0]                wr_mem_line;
    logic [DATA_BUS_WIDTH-1:0] o_data;
    logic                      wr_en;

    modport master (
        input  in_data,
        input  in_valid,
        output in_ready,
        input  group_full,
        output wr_mem_line,
        output o_data,
        output wr_en
    );

    modport slave (
        output in_data,
        output in_valid,
        input  in_ready,
        output group_full,
        input  wr_mem_line,
        input  o_data,
        input  wr_en
    );
endinterface

// File: rtl/spad_fill_ctrl.sv
// rtl/spad_fill_ctrl.sv - write-side sequencer filling KERNEL_SIZE scratchpad lines
module spad_fill_ctrl #(
    parameter int KERNEL_SIZE    = 5,
    parameter int DATA_BUS_WIDTH = 128,
    parameter int LEN_WIDTH      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [LEN_WIDTH-1:0] line_words,
    output logic                 busy,
    output logic                 done,
    spad_fill_ctrl_if.master     bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_LINE = 4'(KERNEL_SIZE - 1);

    state_t                    r_state;
    logic [LEN_WIDTH-1:0]      r_len_q;
    logic [LEN_WIDTH-1:0]      r_word_cnt;
    logic [3:0]                r_line_cnt;
    logic [3:0]                r_wr_mem_line;
    logic [DATA_BUS_WIDTH-1:0] r_o_data;
    logic                      r_wr_en;
    logic                      r_done;

    logic w_in_ready;
    logic w_xfer;
    logic w_last_word;

    assign w_in_ready  = (r_state == S_FILL) && !bus.group_full;
    assign w_xfer      = w_in_ready && bus.in_valid;
    assign w_last_word = (r_word_cnt == r_len_q - LEN_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_len_q       <= '0;
            r_word_cnt    <= '0;
            r_line_cnt    <= '0;
            r_wr_mem_line <= '0;
            r_o_data      <= '0;
            r_wr_en       <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            // abort wins over everything, including a transfer accepted this cycle
            if (abort) begin
                r_state    <= S_IDLE;
                r_word_cnt <= '0;
                r_line_cnt <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_len_q    <= line_words;
                            r_word_cnt <= '0;
                            r_line_cnt <= '0;
                            r_state    <= (line_words == '0) ? S_DONE : S_FILL;
                        end
                    end
                    S_FILL: begin
                        if (w_xfer) begin
                            r_o_data      <= bus.in_data;
                            r_wr_mem_line <= r_line_cnt;
                            r_wr_en       <= 1'b1;
                            if (w_last_word) begin
                                r_word_cnt <= '0;
                                if (r_line_cnt == LAST_LINE) begin
                                    r_line_cnt <= '0;
                                    r_state    <= S_DONE;
                                end else begin
                                    r_line_cnt <= r_line_cnt + 4'd1;
                                end
                            end else begin
                                r_word_cnt <= r_word_cnt + LEN_WIDTH'(1);
                            end
                        end
                    end
                    S_DONE: begin
                        // done lands one cycle after the final write strobe
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.wr_mem_line = r_wr_mem_line;
    assign bus.o_data      = r_o_data;
    assign bus.wr_en       = r_wr_en;
    assign busy            = (r_state != S_IDLE);
    assign done            = r_done;
endmodule

// File: tb/tb_spad_fill_ctrl.sv
// tb/tb_spad_fill_ctrl.sv - directed self-checking bench for spad_fill_ctrl
module tb_spad_fill_ctrl;
    localparam int K = 5;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] line_words;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    spad_fill_ctrl_if #(.DATA_BUS_WIDTH(128)) bus ();

    spad_fill_ctrl #(
        .KERNEL_SIZE(K),
        .DATA_BUS_WIDTH(128),
        .LEN_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .line_words(line_words),
        .busy(busy),
        .done(done),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         st;
        logic         ab;
        logic [7:0]   lw;
        logic         vld;
        logic         gf;
        logic [127:0] d;
        logic         e_rdy;
        logic         e_wr;
        logic         e_busy;
        logic         e_done;
        logic [3:0]   e_line;
        logic [127:0] e_data;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(logic st, logic ab, logic [7:0] lw, logic vld, logic gf,
                                logic [127:0] d, logic e_rdy, logic e_wr, logic e_busy,
                                logic e_done, logic [3:0] e_line, logic [127:0] e_data);
        vec_t v;
        v.st = st; v.ab = ab; v.lw = lw; v.vld = vld; v.gf = gf; v.d = d;
        v.e_rdy = e_rdy; v.e_wr = e_wr; v.e_busy = e_busy; v.e_done = e_done;
        v.e_line = e_line; v.e_data = e_data;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        start = 0; abort = 0; line_words = 0;
        bus.in_valid = 0; bus.group_full = 0; bus.in_data = '0;
    endtask

    // mode 0: valid every cycle, 1: valid every other cycle, 2: group_full for 4 cycles after 3rd transfer
    task automatic fill_run(input int len, input int mode, input int abort_at);
        int           total = K * len;
        int           sent = 0;
        int           writes = 0;
        int           dones = 0;
        int           gf_left = 0;
        int           final_cyc = -1;
        int           abort_cyc = -1;
        int           prev_idx = 0;
        bit           prev_x = 0;
        bit           aborted = 0;
        bit           vld;
        bit           gf;
        bit           ab;
        bit           m_rdy;
        bit           xfer;
        logic [127:0] prev_d = '0;
        logic [127:0] d;

        @(negedge clk);
        start = 1; line_words = 8'(len); bus.in_valid = 0; bus.group_full = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            start = 0;
            if (prev_x && prev_idx == total - 1) final_cyc = cyc;
            chk("run_wr_en", bus.wr_en, prev_x);
            if (prev_x) begin
                chk("run_wr_mem_line", bus.wr_mem_line, 128'(prev_idx / len));
                chk("run_o_data", bus.o_data, prev_d);
            end
            if (bus.wr_en) writes++;
            if (done) dones++;
            chk("run_done", done, (final_cyc >= 0 && cyc == final_cyc + 1));
            chk("run_busy", busy, !aborted && (final_cyc < 0 || cyc == final_cyc));
            if (final_cyc >= 0 && cyc >= final_cyc + 3) break;
            if (aborted && cyc >= abort_cyc + 3) break;

            vld = !aborted && sent < total && (mode != 1 || (cyc % 2) == 0);
            gf = (gf_left > 0);
            if (gf_left > 0) gf_left--;
            m_rdy = !aborted && sent < total && !gf;
            xfer = vld && m_rdy;
            ab = (abort_at != 0) && !aborted && xfer && (sent == abort_at - 1);
            d = {32'(len), 32'(mode), 32'hC0DE0000, 32'(sent)};
            bus.in_valid = vld; bus.group_full = gf; bus.in_data = d; abort = ab;
            #1;
            chk("run_in_ready", bus.in_ready, m_rdy);

            prev_x = xfer && !ab;
            prev_d = d;
            prev_idx = sent;
            if (xfer) sent++;
            if (ab) begin
                aborted = 1;
                abort_cyc = cyc;
            end
            if (mode == 2 && xfer && sent == 3) gf_left = 4;
        end
        chk("run_total_writes", 128'(writes), 128'(aborted ? abort_at - 1 : total));
        chk("run_done_count", 128'(dones), 128'(aborted ? 0 : 1));
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        vecs[0]  = mk(0, 0, 0, 1, 0, 128'h0,  0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 1, 0, 128'h0,  0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 0, 1, 0, 128'h0,  0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(1, 0, 0, 1, 0, 128'h0,  0, 0, 1, 0, 0, 0);
        vecs[4]  = mk(0, 0, 0, 1, 0, 128'h0,  0, 0, 0, 1, 0, 0);
        vecs[5]  = mk(1, 0, 1, 0, 0, 128'h0,  0, 0, 0, 0, 0, 0);
        vecs[6]  = mk(1, 0, 9, 1, 1, 128'hAA, 0, 0, 1, 0, 0, 0);
        vecs[7]  = mk(0, 0, 9, 1, 0, 128'h10, 1, 0, 1, 0, 0, 0);
        vecs[8]  = mk(0, 0, 9, 1, 0, 128'h11, 1, 1, 1, 0, 0, 128'h10);
        vecs[9]  = mk(0, 0, 9, 1, 0, 128'h12, 1, 1, 1, 0, 1, 128'h11);
        vecs[10] = mk(0, 0, 9, 1, 0, 128'h13, 1, 1, 1, 0, 2, 128'h12);
        vecs[11] = mk(0, 0, 9, 1, 0, 128'h14, 1, 1, 1, 0, 3, 128'h13);
        vecs[12] = mk(0, 0, 9, 1, 0, 128'h15, 0, 1, 1, 0, 4, 128'h14);
        vecs[13] = mk(0, 0, 9, 1, 0, 128'h16, 0, 0, 0, 1, 0, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 128'h0,  0, 0, 0, 0, 0, 0);
        vecs[15] = mk(1, 1, 2, 1, 0, 128'h0,  0, 0, 0, 0, 0, 0);
        vecs[16] = mk(0, 0, 2, 1, 0, 128'h0,  0, 0, 0, 0, 0, 0);

        idle_inputs();
        bus.in_valid = 1;
        bus.in_data = 128'hDEAD;
        rst = 0;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", bus.in_ready, 0);
        chk("reset_wr_en", bus.wr_en, 0);
        chk("reset_wr_mem_line", bus.wr_mem_line, 0);
        chk("reset_o_data", bus.o_data, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        rst = 1;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            start = vecs[i].st; abort = vecs[i].ab; line_words = vecs[i].lw;
            bus.in_valid = vecs[i].vld; bus.group_full = vecs[i].gf; bus.in_data = vecs[i].d;
            #1;
            chk($sformatf("vec%0d_in_ready", i), bus.in_ready, vecs[i].e_rdy);
            chk($sformatf("vec%0d_wr_en", i), bus.wr_en, vecs[i].e_wr);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            chk($sformatf("vec%0d_done", i), done, vecs[i].e_done);
            if (vecs[i].e_wr) begin
                chk($sformatf("vec%0d_line", i), bus.wr_mem_line, vecs[i].e_line);
                chk($sformatf("vec%0d_data", i), bus.o_data, vecs[i].e_data);
            end
        end
        @(negedge clk);
        idle_inputs();

        fill_run(3, 0, 0);
        fill_run(2, 2, 0);
        fill_run(4, 1, 0);
        fill_run(4, 0, 7);
        fill_run(4, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
